shift_pipe: RTL

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_pipe_if.sv | 28 ++
 rtl/shift_stage.sv | 56 +++++
 rtl/shift_pipe.sv | 57 +++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: operation encodings, datapath
// widths and the single-step conditional shift used by each stage.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  // One shift of d by amt; the illegal op passes data through untouched.
  function automatic logic [DATA_W-1:0] shift_op(input op_t op,
                                                input logic [DATA_W-1:0] d,
                                                input logic [SHAMT_W-1:0] amt);
    logic [DATA_W-1:0] r;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRA:  r = DATA_W'($signed(d) >>> amt);
      OP_SRL:  r = d >> amt;
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle of the shift pipeline.
interface shift_pipe_if #(parameter int TAG_W = 5) ();
  import shift_pkg::*;

  logic                in_valid;
  logic                in_ready;
  op_t                 in_op;
  logic [DATA_W-1:0]   in_data;
  logic [SHAMT_W-1:0]  in_shamt;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [TAG_W-1:0]    out_tag;
  logic                out_err;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  // The shift pipeline itself.
  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/shift_stage.sv
// One pipeline slot: a set of conditional power-of-two shifts in front of a
// valid-qualified register. SH_W shamt bits are applied, bit j weighing
// 2**(SH_LSB+j). CARRY is opaque payload (tag, leftover shamt) moved along.
module shift_stage
  import shift_pkg::*;
#(
  parameter int SH_W    = 2,
  parameter int SH_LSB  = 3,
  parameter int CARRY_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               up_valid,
  output logic               up_ready,
  input  op_t                up_op,
  input  logic [DATA_W-1:0]  up_data,
  input  logic [SH_W-1:0]    up_sh,
  input  logic [CARRY_W-1:0] up_carry,
  output logic               dn_valid,
  input  logic               dn_ready,
  output op_t                dn_op,
  output logic [DATA_W-1:0]  dn_data,
  output logic [CARRY_W-1:0] dn_carry
);

  logic [DATA_W-1:0] shifted;

  // Chain of conditional shifts selected by this stage's shamt bits.
  always_comb begin
    shifted = up_data;
    for (int j = SH_W - 1; j >= 0; j--)
      if (up_sh[j]) shifted = shift_op(up_op, shifted, SHAMT_W'(1 << (SH_LSB + j)));
  end

  // Slot can load when empty or when its content leaves this cycle.
  assign up_ready = !dn_valid || dn_ready;

  // Slot register; payload only loads on a real transfer so a stalled or
  // empty slot keeps its contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dn_valid <= 1'b0;
      dn_op    <= OP_SLL;
      dn_data  <= '0;
      dn_carry <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_op    <= up_op;
        dn_data  <= shifted;
        dn_carry <= up_carry;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage barrel shifter: S1 applies shamt[4:3] (16, 8), S2 applies
// shamt[2:0] (4, 2, 1). Elastic valid/ready handshake, tag rides along.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic         clock,
  input  logic         reset,
  shift_pipe_if.slave  bus
);

  localparam int REM_W = 3;  // shamt bits left for S2

  logic                     s1_valid;
  logic                     s2_ready;
  op_t                      s1_op;
  logic [DATA_W-1:0]        s1_data;
  logic [TAG_W+REM_W-1:0]   s1_carry;
  op_t                      s2_op;

  shift_stage #(.SH_W(2), .SH_LSB(3), .CARRY_W(TAG_W + REM_W)) u_s1 (
    .clock    (clock),
    .reset    (reset),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .up_op    (bus.in_op),
    .up_data  (bus.in_data),
    .up_sh    (bus.in_shamt[4:3]),
    .up_carry ({bus.in_tag, bus.in_shamt[REM_W-1:0]}),
    .dn_valid (s1_valid),
    .dn_ready (s2_ready),
    .dn_op    (s1_op),
    .dn_data  (s1_data),
    .dn_carry (s1_carry)
  );

  shift_stage #(.SH_W(REM_W), .SH_LSB(0), .CARRY_W(TAG_W)) u_s2 (
    .clock    (clock),
    .reset    (reset),
    .up_valid (s1_valid),
    .up_ready (s2_ready),
    .up_op    (s1_op),
    .up_data  (s1_data),
    .up_sh    (s1_carry[REM_W-1:0]),
    .up_carry (s1_carry[REM_W +: TAG_W]),
    .dn_valid (bus.out_valid),
    .dn_ready (bus.out_ready),
    .dn_op    (s2_op),
    .dn_data  (bus.out_data),
    .dn_carry (bus.out_tag)
  );

  // Illegal op travels as its own encoding; reset op is SLL so err clears.
  assign bus.out_err = (s2_op == OP_ILL);

endmodule
